bcd_display_driver: RTL and testbench
=====================================

# bcd_display_driver

Parametrised binary-to-seven-segment display driver for the board's multi-digit LED display. It accepts a binary value with a start strobe and converts it to BCD serially using double-dabble, one bit per clock. It then applies leading-zero blanking, decimal-point placement and overflow indication, and registers all digit patterns together. It replaces the fixed six-digit, pre-BCD decode path wherever a raw binary count (timer, counter, ALU result) must be shown.

## Interface
- DIGITS, 6: number of display digits, 1..8.
- BIN_W, 20: width of the binary input, 1..27.
- clk  in  1: system clock, rising edge.
- reset  in  1: asynchronous, active-high reset.
- start  in  1: request a conversion; sampled only in IDLE.
- bin_in  in  BIN_W: unsigned value, captured when start is accepted.
- dp_pos  in  $clog2(DIGITS+1): 0 means no decimal point; k means the dp is lit on digit k-1. Values above DIGITS are treated as 0.
- blank_lz  in  1: enable leading-zero blanking.
- busy  out  1: high from the accepting edge until the UPDATE edge.
- done  out  1: one-cycle pulse, coincident with the new seg_out.
- overflow  out  1: the last conversion exceeded 10^DIGITS-1.
- seg_out  out  8*DIGITS: digit i occupies [8i+7:8i]; digit 0 is least significant. Bit order within a digit is {dp,g,f,e,d,c,b,a}, active-low.

## Operation
- The FSM has three states: IDLE, SHIFT and UPDATE.
- IDLE:
  - When start=1, capture bin_in, dp_pos (clamped) and blank_lz.
  - Clear the BCD register, which is 4*DIGITS bits.
  - Latch ovf_cap = (bin_in > MAXV), where MAXV = 10^DIGITS-1.
  - Load the bit counter with BIN_W, set busy=1 and go to SHIFT.
- SHIFT, each cycle:
  - Add 3 to every BCD nibble that is ≥5.
  - Shift {bcd, bin} left one bit and decrement the counter.
  - Go to UPDATE after BIN_W shifts.
  - BCD bits shifted beyond 4*DIGITS are discarded; this only happens when ovf_cap=1.
- UPDATE:
  - Register all seg_out digits, set overflow=ovf_cap, pulse done=1, clear busy and return to IDLE.
- start is ignored in SHIFT and UPDATE; no queueing.
- Digit pattern rules:
  - If overflow, every digit shows '-' (0xBF) with the dp off.
  - Otherwise, digit i shows its BCD nibble. The dp is lit (bit7=0) when i = dp_pos-1.
  - With blank_lz=1, digit i is blanked (0xFF) when all nibbles at indices ≥ i are zero, i > 0, and i > dp_pos-1. Digit 0, and any digit at or below the dp digit, is never blanked.
- Encodings (dp off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99
  - 5=92, 6=82, 7=F8, 8=80, 9=90
  - blank=FF, '-'=BF
- seg_out holds its value between conversions.

## Timing
- Start is accepted at edge 0. SHIFT occupies edges 1..BIN_W, and UPDATE is edge BIN_W+1.
- done and the new seg_out/overflow are visible after edge BIN_W+1, so latency is BIN_W+1 cycles.
- busy is high for exactly BIN_W+1 cycles. The earliest next accept is edge BIN_W+2, so back-to-back throughput is one conversion per BIN_W+2 cycles.
- Reset values: state IDLE, busy 0, done 0, overflow 0, every seg_out digit FF.
- Reset asserted mid-conversion aborts it immediately: no done, outputs return to the reset values, and the captured data is discarded.
- If start is held high across UPDATE, the next conversion is accepted on the first IDLE edge.

## Structure
- Shared package bcd_disp_pkg holds:
  - the state enum
  - the segment constants (digits 0-9, SEG_BLANK, SEG_DASH)
  - a constant function pow10(n) used for MAXV.
- Sub-module seg7_encode is combinational: 4-bit nibble plus dp plus blank plus dash in, 8-bit pattern out. It is instantiated DIGITS times in a generate loop.
- The serial BCD core stays in the top module with the FSM.

## Test plan
- Reset with start=1 held → seg_out = all FF, busy=0, done=0, overflow=0 throughout reset.
- DIGITS=6, BIN_W=20: start with bin_in=123456, dp_pos=0, blank_lz=0.
  - done pulses 21 cycles after the accepting edge.
  - Digits 5..0 read F9,A4,B0,99,92,82 and overflow=0.
- bin_in=5, dp_pos=3, blank_lz=1 → digits 5..3 = FF, digit 2 = 40 ('0.'), digit 1 = C0, digit 0 = 92.
- bin_in=1000000 → overflow=1 and all digits BF. A following bin_in=0 with blank_lz=1 gives overflow=0, digit 0 = C0, others FF.
- start pulsed at cycles 5 and 21 after the first accept (mid-SHIFT and in UPDATE) → both ignored, exactly one done, seg_out reflects the first value only.
- reset pulsed at SHIFT cycle 10 → no done, seg_out returns to FF. A new start after release converts correctly.

Source files
------------

// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: shared FSM states, seven-segment codes and helpers for bcd_display_driver
package bcd_disp_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    function automatic logic [7:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bcd_display_driver_seg7_encode.sv
// seg7_encode: one BCD nibble to an active-low {dp,g..a} pattern with blank and dash overrides
module seg7_encode
    import bcd_disp_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       dp,
    input  logic       blank,
    input  logic       dash,
    output logic [7:0] seg
);

    assign seg = dash ? SEG_DASH : blank ? SEG_BLANK : seg_of(nib) & {~dp, 7'h7F};

endmodule

// File: rtl/bcd_display_driver.sv
// bcd_display_driver: serial double-dabble binary-to-BCD with blanking, dp and overflow to 7-seg
module bcd_display_driver
    import bcd_disp_pkg::*;
#(
    parameter int DIGITS = 6,
    parameter int BIN_W  = 20
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [BIN_W-1:0]             bin_in,
    input  logic [$clog2(DIGITS+1)-1:0]  dp_pos,
    input  logic                         blank_lz,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow,
    output logic [8*DIGITS-1:0]          seg_out
);

    localparam int CW  = $clog2(BIN_W + 1);
    localparam int BW  = 4 * DIGITS;
    localparam int DPW = $clog2(DIGITS + 1);
    localparam logic [63:0] MAXV = pow10(DIGITS) - 64'd1;

    state_t              state, nxt;
    logic [BIN_W-1:0]    bin_r;
    logic [BW-1:0]       bcd, adj;
    logic [CW-1:0]       cnt;
    logic [DPW-1:0]      dp_r;
    logic                blz_r, ovf_cap, z;
    logic [DIGITS-1:0]   blank, dp_on;
    logic [8*DIGITS-1:0] seg_nxt;

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= nxt;

    always_comb
        nxt = state == IDLE  ? (start ? SHIFT : IDLE) :
              state == SHIFT ? (cnt == CW'(1) ? UPDATE : SHIFT) : IDLE;

    assign busy = state != IDLE;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < DIGITS; i++)
            adj[4*i+:4] = bcd[4*i+:4] >= 4'd5 ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
    end

    // z tracks "every nibble from the top down to i is zero" for leading-zero blanking
    always_comb begin
        z     = 1'b1;
        blank = '0;
        dp_on = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            z        = z & (bcd[4*i+:4] == 4'd0);
            blank[i] = blz_r & z & (i > 0) & (i >= int'(dp_r));
            dp_on[i] = int'(dp_r) == i + 1;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_enc
        seg7_encode u_enc (
            .nib   (bcd[4*g+:4]),
            .dp    (dp_on[g]),
            .blank (blank[g]),
            .dash  (ovf_cap),
            .seg   (seg_nxt[8*g+:8])
        );
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            bin_r    <= '0;
            bcd      <= '0;
            cnt      <= '0;
            dp_r     <= '0;
            blz_r    <= 1'b0;
            ovf_cap  <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            seg_out  <= '1;
        end else begin
            done <= state == UPDATE;
            if (state == IDLE && start) begin
                bin_r   <= bin_in;
                bcd     <= '0;
                cnt     <= CW'(BIN_W);
                dp_r    <= int'(dp_pos) > DIGITS ? '0 : dp_pos;
                blz_r   <= blank_lz;
                ovf_cap <= 64'(bin_in) > MAXV;
            end else if (state == SHIFT) begin
                {bcd, bin_r} <= {adj, bin_r} << 1;
                cnt          <= cnt - CW'(1);
            end else if (state == UPDATE) begin
                seg_out  <= seg_nxt;
                overflow <= ovf_cap;
            end
        end

endmodule

// File: tb/tb_bcd_display_driver.sv
// tb_bcd_display_driver: table vectors, corner sequences and randomized model checks
module tb_bcd_display_driver;

    localparam logic [7:0] ENC [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [19:0] bin_in = '0;
    logic [2:0]  dp_pos = '0;
    logic        blank_lz = 1'b0;
    logic        busy, done, overflow;
    logic [47:0] seg_out;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [19:0] b;
        logic [2:0]  d;
        logic        bz;
        logic [47:0] seg;
        logic        ovf;
    } vec_t;

    vec_t tbl [8];

    bcd_display_driver #(.DIGITS(6), .BIN_W(20)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bin_in   (bin_in),
        .dp_pos   (dp_pos),
        .blank_lz (blank_lz),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .seg_out  (seg_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // reference: decimal digits by division, blanking as "value < 10^i"
    function automatic logic [48:0] model(input int unsigned b, input int d, input bit bz);
        logic [47:0] s;
        logic [7:0]  c;
        int unsigned p;
        int          dd;
        dd = d > 6 ? 0 : d;
        if (b > 999999) return {1'b1, {6{8'hBF}}};
        p = 1;
        for (int i = 0; i < 6; i++) begin
            c = ENC[(b / p) % 10];
            if (dd == i + 1) c[7] = 1'b0;
            if (bz && i > 0 && i >= dd && b < p) c = 8'hFF;
            s[8*i+:8] = c;
            p = p * 10;
        end
        return {1'b0, s};
    endfunction

    // called #1 after an edge with the DUT idle; returns cycles from accept edge to done
    task automatic convert(input logic [19:0] b, input logic [2:0] d, input logic bz, output int lat);
        bin_in = b; dp_pos = d; blank_lz = bz; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1 lat++;
        end
    endtask

    initial begin
        int lat, nd, t0, t1, c;
        logic [48:0] e;
        tbl[0] = '{20'd123456,  3'd0, 1'b0, 48'hF9A4B0999282, 1'b0};
        tbl[1] = '{20'd5,       3'd3, 1'b1, 48'hFFFFFF40C092, 1'b0};
        tbl[2] = '{20'd1000000, 3'd0, 1'b0, 48'hBFBFBFBFBFBF, 1'b1};
        tbl[3] = '{20'd0,       3'd0, 1'b1, 48'hFFFFFFFFFFC0, 1'b0};
        tbl[4] = '{20'd999999,  3'd0, 1'b1, 48'h909090909090, 1'b0};
        tbl[5] = '{20'd42,      3'd7, 1'b1, 48'hFFFFFFFF99A4, 1'b0};
        tbl[6] = '{20'd7,       3'd6, 1'b1, 48'h40C0C0C0C0F8, 1'b0};
        tbl[7] = '{20'hFFFFF,   3'd2, 1'b1, 48'hBFBFBFBFBFBF, 1'b1};

        start = 1'b1; bin_in = 20'd77;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_seg", seg_out, 48'hFFFFFFFFFFFF);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_ovf", overflow, 0);
        end
        start = 1'b0; reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            convert(tbl[i].b, tbl[i].d, tbl[i].bz, lat);
            check("tbl_lat", lat, 21);
            check("tbl_seg", seg_out, tbl[i].seg);
            check("tbl_ovf", overflow, tbl[i].ovf);
        end

        // start pulses mid-SHIFT and during UPDATE must be ignored
        bin_in = 20'd222; dp_pos = 3'd0; blank_lz = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("busy_accept", busy, 1);
        nd = 0;
        for (c = 1; c <= 30; c++) begin
            start = (c == 5 || c == 21);
            bin_in = 20'd999999;
            @(posedge clk); #1;
            if (done) nd++;
            if (c == 20) check("busy_pre_upd", busy, 1);
            if (c == 21) begin
                check("done_at_21", done, 1);
                check("busy_cleared", busy, 0);
            end
        end
        start = 1'b0;
        check("ign_ndone", nd, 1);
        check("ign_seg", seg_out, 48'hFFFFFFA4A4A4);
        check("ign_busy", busy, 0);

        // start held high: accept on first IDLE edge after UPDATE
        bin_in = 20'd111111; dp_pos = 3'd0; blank_lz = 1'b0; start = 1'b1;
        t0 = 0; t1 = 0;
        for (c = 1; c <= 50; c++) begin
            @(posedge clk); #1;
            if (done && t0 == 0) t0 = c;
            else if (done) t1 = c;
        end
        start = 1'b0;
        check("held_first", t0, 22);
        check("held_gap", t1 - t0, 22);
        check("held_seg", seg_out, 48'hF9F9F9F9F9F9);
        c = 0;
        while (!done && c < 40) begin
            @(posedge clk); #1 c++;
        end
        check("held_drain", done, 1);

        // reset mid-SHIFT aborts the conversion
        @(posedge clk); #1;
        bin_in = 20'd333; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_seg", seg_out, 48'hFFFFFFFFFFFF);
        check("abort_busy", busy, 0);
        check("abort_ovf", overflow, 0);
        @(posedge clk); #1 reset = 1'b0;
        nd = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        check("abort_ndone", nd, 0);
        check("abort_hold", seg_out, 48'hFFFFFFFFFFFF);
        convert(20'd654321, 3'd0, 1'b0, lat);
        check("post_lat", lat, 21);
        check("post_seg", seg_out, 48'h829299B0A4F9);

        for (int i = 0; i < 25; i++) begin
            logic [19:0] b;
            logic [2:0]  d;
            logic        bz;
            b  = $urandom_range(0, 1) ? 20'($urandom_range(0, 20'hFFFFF)) : 20'($urandom_range(0, 999));
            d  = 3'($urandom_range(0, 7));
            bz = 1'($urandom_range(0, 1));
            convert(b, d, bz, lat);
            e = model(int'(b), int'(d), bz);
            check("rnd_lat", lat, 21);
            check("rnd_seg", seg_out, e[47:0]);
            check("rnd_ovf", overflow, e[48]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
